button_in: RTL and testbench
============================

BUTTON_IN -- requirements
Module: button_in

Interface
REQ-001 Parameter WIDTH, default 3, debounce counter width; the debounce interval is 2^WIDTH cycles.
REQ-002 Parameter HOLD, default 5, long-press counter width; the long-press threshold is 2^HOLD-1 cycles held.
REQ-003 Parameter ACTIVE_LOW, default 1, pin polarity; 1 means a low pin level = pressed.
REQ-004 i_clk  input  1  sole clock, all state on rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 i_pin  input  1  raw asynchronous button/touch-pad level.
REQ-007 o_level  output  1  debounced pressed level (1 = pressed).
REQ-008 o_press  output  1  one-cycle strobe on debounced press.
REQ-009 o_release  output  1  one-cycle strobe on debounced release.
REQ-010 o_long  output  1  one-cycle strobe when a press has been held for the long-press threshold.
REQ-011 o_count  output  4  press count, wraps modulo 16.

Function
REQ-012 i_pin SHALL pass through a 2-flop synchronizer; the result is normalised to s (1 = pressed) per ACTIVE_LOW.
REQ-013 The FSM SHALL have 4 states: UP, DN_WAIT, DOWN, UP_WAIT.
REQ-014 UP: s=1 -> DN_WAIT with the debounce counter cleared to 0; s=0 -> stay.
REQ-015 DN_WAIT: s=0 -> UP with no strobe; s=1 and counter<2^WIDTH-1 -> counter+1; s=1 and counter=2^WIDTH-1 -> DOWN.
REQ-016 On entering DOWN: o_press=1 for exactly that first DOWN cycle, o_level=1, o_count+1 (15->0), hold counter cleared to 0.
REQ-017 DOWN: hold counter increments each cycle and saturates at 2^HOLD-1; o_long SHALL pulse in the single cycle the hold counter first reaches 2^HOLD-1, at most once per press.
REQ-018 DOWN: s=0 -> UP_WAIT with the debounce counter cleared.
REQ-019 UP_WAIT: s=1 -> DOWN with no strobes, hold counter and long flag kept (the glitch is ignored); s=0 -> count as in REQ-015, and at 2^WIDTH-1 -> UP.
REQ-020 On entering UP: o_release=1 for that first cycle; o_level=0 in the same cycle.
REQ-021 Latency: a clean pin edge settling before edge E0 SHALL yield its strobe in the cycle after edge E(2^WIDTH+2), i.e. 11 edges for WIDTH=3.
REQ-022 Hold counting SHALL continue through UP_WAIT.
REQ-023 o_press, o_release and o_long SHALL never be high simultaneously with each other except o_long with nothing; all outputs are registered.

Reset
REQ-024 With i_rst=1 at a clock edge: state=UP, both counters=0, long flag=0, synchronizer flops=inactive pin level, o_level=0, o_press=o_release=o_long=0, o_count=0.
REQ-025 Reset mid-press SHALL abort without a release strobe; a pin still held after reset SHALL be re-debounced and produce a fresh o_press.

Structure
REQ-026 No shared package; state encodings and counter maxima SHALL be localparams inside button_in.
REQ-027 The synchronizer SHALL be a separate sub-module sync2 (parameter INIT for the flop reset value), reusable for other pad inputs.

Verification (WIDTH=3, HOLD=5, ACTIVE_LOW=1)
REQ-028 Reset, i_pin=1 for 50 cycles -> all outputs 0, o_count=0.
REQ-029 i_pin 1->0 held -> o_press exactly one cycle, 11 edges after the change; o_level=1; o_count=1.
REQ-030 Press glitch: i_pin low for 5 cycles, then high -> no strobes, o_level stays 0, o_count unchanged.
REQ-031 Held press for 40 cycles -> exactly one o_long, 31 cycles after o_press; release -> one o_release 11 edges after the pin rises.
REQ-032 16 clean press/release cycles -> o_count returns to 0; 16 o_press and 16 o_release pulses.
REQ-033 i_rst asserted while in DOWN with pin still low -> outputs cleared, no o_release, new o_press 11 edges after the cycle in which i_rst deasserts.

Source files
------------

// File: rtl/button_in_sync2.sv
// Two-flop synchronizer for asynchronous pad inputs.
// The flops reset to INIT so a released pad reads as idle straight out of reset.
module sync2 #(
  parameter logic INIT = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta <= INIT;
      o_q  <= INIT;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/button_in.sv
// Debounced button input: press/release/long-press strobes and a press counter.
// Every output is registered, so each strobe appears on the edge that changes state.
module button_in #(
  parameter int WIDTH      = 3,
  parameter int HOLD       = 5,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pin,
  output logic       o_level,
  output logic       o_press,
  output logic       o_release,
  output logic       o_long,
  output logic [3:0] o_count
);

  typedef enum logic [1:0] {
    UP      = 2'd0,
    DN_WAIT = 2'd1,
    DOWN    = 2'd2,
    UP_WAIT = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] DB_MAX   = '1;
  localparam logic [HOLD-1:0]  HOLD_MAX = '1;
  localparam logic [HOLD-1:0]  HOLD_PRE = HOLD_MAX - 1'b1;

  state_t           state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [HOLD-1:0]  hold, hold_n;
  logic             long_flag, long_flag_n;
  logic             level_n, press_n, release_n, long_n;
  logic [3:0]       count_n;
  logic             pin_q, s;

  sync2 #(.INIT(ACTIVE_LOW)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_pin),
    .o_q   (pin_q)
  );

  assign s = ACTIVE_LOW ? ~pin_q : pin_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= UP;
      cnt       <= '0;
      hold      <= '0;
      long_flag <= 1'b0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
      o_count   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      hold      <= hold_n;
      long_flag <= long_flag_n;
      o_level   <= level_n;
      o_press   <= press_n;
      o_release <= release_n;
      o_long    <= long_n;
      o_count   <= count_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    hold_n      = hold;
    long_flag_n = long_flag;
    level_n     = o_level;
    press_n     = 1'b0;
    release_n   = 1'b0;
    long_n      = 1'b0;
    count_n     = o_count;
    unique case (state)
      UP: begin
        if (s) begin
          state_n = DN_WAIT;
          cnt_n   = '0;
        end
      end
      DN_WAIT: begin
        if (!s) begin
          state_n = UP;
        end else if (cnt != DB_MAX) begin
          cnt_n = cnt + 1'b1;
        end else begin
          state_n     = DOWN;
          press_n     = 1'b1;
          level_n     = 1'b1;
          count_n     = o_count + 4'd1;
          hold_n      = '0;
          long_flag_n = 1'b0;
        end
      end
      DOWN, UP_WAIT: begin
        // Hold time keeps accruing while a release is being debounced.
        if (hold != HOLD_MAX) hold_n = hold + 1'b1;
        if (hold == HOLD_PRE && !long_flag) begin
          long_n      = 1'b1;
          long_flag_n = 1'b1;
        end
        if (state == DOWN) begin
          if (!s) begin
            state_n = UP_WAIT;
            cnt_n   = '0;
          end
        end else if (s) begin
          state_n = DOWN;
        end else if (cnt != DB_MAX) begin
          cnt_n = cnt + 1'b1;
        end else begin
          state_n     = UP;
          release_n   = 1'b1;
          level_n     = 1'b0;
          hold_n      = hold;
          long_n      = 1'b0;
          long_flag_n = long_flag;
        end
      end
      default: state_n = UP;
    endcase
  end

endmodule

// File: tb/tb_button_in.sv
// Directed bench for button_in: strobes are scored against a queue of
// expected (kind, cycle) events pushed as each pin change is driven.
module tb_button_in;

  logic       clk = 1'b0;
  logic       rst;
  logic       pin;
  logic       level, press, rel, lng;
  logic [3:0] count;

  int cyc = 0;
  int checks = 0;
  int passed = 0;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  ev_t q[$];

  button_in #(.WIDTH(3), .HOLD(5), .ACTIVE_LOW(1'b1)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_pin     (pin),
    .o_level   (level),
    .o_press   (press),
    .o_release (rel),
    .o_long    (lng),
    .o_count   (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (press || rel || lng) begin
      int k;
      ev_t e;
      k = press ? 0 : (rel ? 1 : 2);
      checks++;
      assert ($onehot({press, rel, lng}))
        passed++;
      else $error("FAIL onehot got %b%b%b", press, rel, lng);
      checks++;
      assert (q.size() > 0)
        passed++;
      else $error("FAIL unexpected kind=%0d at %0d", k, cyc);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        assert (k === e.kind && cyc === e.at)
          passed++;
        else $error("FAIL event got k%0d@%0d want k%0d@%0d",
                    k, cyc, e.kind, e.at);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [4:0] got,
                     input logic [4:0] exp);
    checks++;
    assert (got === exp)
      passed++;
    else $error("FAIL %s got %h want %h", tag, got, exp);
  endtask

  task automatic expect_ev(input int kind, input int dly);
    ev_t e;
    e.kind = kind;
    e.at   = cyc + dly;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    pin = 1'b1;
    step(3);
    chk("rst_out", {level, press, rel, lng, 1'b0}, 5'd0);
    chk("rst_cnt", {1'b0, count}, 5'd0);
    rst = 1'b0;
    step(50);
    chk("idle_lvl", {4'd0, level}, 5'd0);
    chk("idle_cnt", {1'b0, count}, 5'd0);

    pin = 1'b0;
    expect_ev(0, 11);
    step(20);
    chk("p1_lvl", {4'd0, level}, 5'd1);
    chk("p1_cnt", {1'b0, count}, 5'd1);
    pin = 1'b1;
    expect_ev(1, 11);
    step(20);
    chk("r1_lvl", {4'd0, level}, 5'd0);

    pin = 1'b0;
    step(5);
    pin = 1'b1;
    step(20);
    chk("gl_lvl", {4'd0, level}, 5'd0);
    chk("gl_cnt", {1'b0, count}, 5'd1);

    pin = 1'b0;
    expect_ev(0, 11);
    expect_ev(2, 42);
    step(60);
    chk("lp_lvl", {4'd0, level}, 5'd1);
    pin = 1'b1;
    expect_ev(1, 11);
    step(20);
    chk("lp_cnt", {1'b0, count}, 5'd2);

    pin = 1'b0;
    expect_ev(0, 11);
    step(15);
    pin = 1'b1;
    step(3);
    pin = 1'b0;
    step(10);
    chk("ug_lvl", {4'd0, level}, 5'd1);
    pin = 1'b1;
    expect_ev(1, 11);
    step(20);
    chk("ug_cnt", {1'b0, count}, 5'd3);

    for (int i = 0; i < 16; i++) begin
      pin = 1'b0;
      expect_ev(0, 11);
      step(15);
      pin = 1'b1;
      expect_ev(1, 11);
      step(15);
    end
    chk("wrap_cnt", {1'b0, count}, 5'd3);

    pin = 1'b0;
    expect_ev(0, 11);
    step(20);
    chk("pr_cnt", {1'b0, count}, 5'd4);
    rst = 1'b1;
    step(1);
    chk("mid_rst", {level, press, rel, lng, 1'b0}, 5'd0);
    chk("mid_cnt", {1'b0, count}, 5'd0);
    rst = 1'b0;
    expect_ev(0, 11);
    step(20);
    chk("re_lvl", {4'd0, level}, 5'd1);
    chk("re_cnt", {1'b0, count}, 5'd1);
    pin = 1'b1;
    expect_ev(1, 11);
    step(20);

    checks++;
    assert (q.size() == 0)
      passed++;
    else $error("FAIL pending got %0d want 0", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
